preif_utlb_stage: RTL and testbench

- Next-generation pre-IF stage. Generates the fetch PC, translates it through a parametrised fully-associative micro-ITLB, and issues requests to the inst cache over a valid/addr_ok handshake.
- On a micro-TLB miss it queries main TLB search port 0 through a small FSM and refills one entry, chosen round-robin.
- Sits between the branch/reflush sources and the IF stage. Passes the PC and exception information to IF.

---
 rtl/preif_utlb_stage_pkg.sv | 27 ++
 rtl/preif_utlb_stage_if.sv | 41 ++++
 rtl/preif_utlb_stage_utlb_array.sv | 71 +++++++
 rtl/preif_utlb_stage.sv | 141 ++++++++++++++
 tb/tb_preif_utlb_stage.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/preif_utlb_stage_pkg.sv
// Shared definitions for the pre-IF stage: exception codes, FSM states and
// kseg address-decode helpers.
package preif_utlb_stage_pkg;

  localparam logic [4:0] EXC_NONE = 5'h0;
  localparam logic [4:0] EXC_ADEL = 5'h4;
  localparam logic [4:0] EXC_TLBL = 5'h2;

  // {pc, exc, exc_code, tlb_refill} as seen by the IF stage
  localparam int PF_TO_FS_BUS_WD = 32 + 1 + 5 + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_QUERY,
    S_EXC
  } state_t;

  // kseg0/kseg1 bypass the TLB
  function automatic logic is_unmapped(input logic [31:0] va);
    return va[31:30] == 2'b10;
  endfunction

  function automatic logic [31:0] unmapped_paddr(input logic [31:0] va);
    return {3'b000, va[28:0]};
  endfunction

endpackage

// File: rtl/preif_utlb_stage_if.sv
// Bus bundle of the pre-IF stage: IF handoff, inst cache request port and
// main-TLB search port 0. The stage is the master side.
interface preif_utlb_stage_if #(
  parameter int ASID_W = 8
);

  logic              fs_allowin;
  logic              to_fs_valid;
  logic [31:0]       pfs_pc;
  logic              pfs_exc;
  logic [4:0]        pfs_exc_code;
  logic              pfs_tlb_refill;

  logic              inst_cache_valid;
  logic              inst_cache_uncache;
  logic [31:0]       inst_cache_addr;
  logic              inst_cache_addr_ok;

  logic [18:0]       s0_vpn2;
  logic              s0_odd_page;
  logic [ASID_W-1:0] s0_asid;
  logic              s0_found;
  logic [19:0]       s0_pfn;
  logic [2:0]        s0_c;
  logic              s0_v;

  modport master (
    input  fs_allowin, inst_cache_addr_ok, s0_found, s0_pfn, s0_c, s0_v,
    output to_fs_valid, pfs_pc, pfs_exc, pfs_exc_code, pfs_tlb_refill,
           inst_cache_valid, inst_cache_uncache, inst_cache_addr,
           s0_vpn2, s0_odd_page, s0_asid
  );

  modport slave (
    output fs_allowin, inst_cache_addr_ok, s0_found, s0_pfn, s0_c, s0_v,
    input  to_fs_valid, pfs_pc, pfs_exc, pfs_exc_code, pfs_tlb_refill,
           inst_cache_valid, inst_cache_uncache, inst_cache_addr,
           s0_vpn2, s0_odd_page, s0_asid
  );

endinterface

// File: rtl/preif_utlb_stage_utlb_array.sv
// Fully-associative micro-ITLB storage: parallel match, round-robin refill
// and whole-array flush.
module preif_utlb_stage_utlb_array #(
  parameter int ENTRIES = 4,
  parameter int ASID_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [18:0]       vpn2,
  input  logic              odd,
  input  logic [ASID_W-1:0] asid,
  input  logic              fill,
  input  logic [19:0]       fill_pfn,
  input  logic [2:0]        fill_c,
  input  logic              flush,
  output logic              hit,
  output logic [19:0]       hit_pfn,
  output logic [2:0]        hit_c
);

  localparam int PTR_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] valid;
  logic [18:0]        e_vpn2 [ENTRIES];
  logic               e_odd  [ENTRIES];
  logic [ASID_W-1:0]  e_asid [ENTRIES];
  logic [19:0]        e_pfn  [ENTRIES];
  logic [2:0]         e_c    [ENTRIES];
  logic [PTR_W-1:0]   rr_ptr;
  logic [ENTRIES-1:0] match;

  // Flush has priority so a fill racing a TLB write never survives it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid  <= '0;
      rr_ptr <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        e_vpn2[i] <= '0;
        e_odd[i]  <= 1'b0;
        e_asid[i] <= '0;
        e_pfn[i]  <= '0;
        e_c[i]    <= '0;
      end
    end else if (flush) begin
      valid <= '0;
    end else if (fill) begin
      valid[rr_ptr]  <= 1'b1;
      e_vpn2[rr_ptr] <= vpn2;
      e_odd[rr_ptr]  <= odd;
      e_asid[rr_ptr] <= asid;
      e_pfn[rr_ptr]  <= fill_pfn;
      e_c[rr_ptr]    <= fill_c;
      rr_ptr         <= rr_ptr + PTR_W'(1);
    end
  end

  // A VPN is never filled twice, so at most one match bit is set
  always_comb begin
    hit     = 1'b0;
    hit_pfn = '0;
    hit_c   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      match[i] = valid[i] && (e_vpn2[i] == vpn2) && (e_odd[i] == odd) &&
                 (e_asid[i] == asid);
      hit      = hit | match[i];
      hit_pfn  = hit_pfn | ({20{match[i]}} & e_pfn[i]);
      hit_c    = hit_c | ({3{match[i]}} & e_c[i]);
    end
  end

endmodule

// File: rtl/preif_utlb_stage.sv
// Pre-IF stage: fetch PC generation, micro-ITLB translation with main-TLB
// refill FSM, inst cache request issue and exception tokens for IF.
module preif_utlb_stage
  import preif_utlb_stage_pkg::*;
#(
  parameter int          UTLB_ENTRIES = 4,
  parameter logic [31:0] RESET_PC     = 32'hbfc00000,
  parameter int          ASID_W       = 8,
  parameter int          OFS_W        = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              br_valid,
  input  logic [31:0]       br_target,
  input  logic              pfs_reflush,
  input  logic [31:0]       reflush_pc,
  input  logic [OFS_W-1:0]  inst_offset,
  input  logic              tlb_write,
  input  logic [ASID_W-1:0] cp0_asid,
  preif_utlb_stage_if.master bus
);

  state_t      state, state_n;
  logic [31:0] cur_pc;
  logic        refill_r, refill_n;

  logic        adel, unmapped, redirect, fill_en;
  logic        hit;
  logic [19:0] hit_pfn;
  logic [2:0]  hit_c;
  logic        req, exc_tok, tok, qry;
  logic [4:0]  exc_code;
  logic [31:0] phys;
  logic        uncache;

  assign adel     = cur_pc[1:0] != 2'b00;
  assign unmapped = is_unmapped(cur_pc);
  assign redirect = pfs_reflush | br_valid;
  assign fill_en  = (state == S_QUERY) && !reset && !redirect && !tlb_write &&
                    bus.s0_found && bus.s0_v;

  preif_utlb_stage_utlb_array #(
    .ENTRIES (UTLB_ENTRIES),
    .ASID_W  (ASID_W)
  ) u_utlb (
    .clk      (clk),
    .reset    (reset),
    .vpn2     (cur_pc[31:13]),
    .odd      (cur_pc[12]),
    .asid     (cp0_asid),
    .fill     (fill_en),
    .fill_pfn (bus.s0_pfn),
    .fill_c   (bus.s0_c),
    .flush    (tlb_write),
    .hit      (hit),
    .hit_pfn  (hit_pfn),
    .hit_c    (hit_c)
  );

  assign phys    = unmapped ? unmapped_paddr(cur_pc) : {hit_pfn, cur_pc[11:0]};
  assign uncache = unmapped ? cur_pc[29] : (hit_c != 3'd3);

  // Outputs stay quiet while reset is held, apart from the PC
  always_comb begin
    state_n  = state;
    refill_n = refill_r;
    req      = 1'b0;
    exc_tok  = 1'b0;
    tok      = 1'b0;
    qry      = 1'b0;
    exc_code = EXC_NONE;
    if (!reset) begin
      case (state)
        S_IDLE: begin
          if (adel) begin
            exc_tok  = 1'b1;
            exc_code = EXC_ADEL;
            tok      = bus.fs_allowin;
          end else if (unmapped || hit) begin
            req = bus.fs_allowin;
          end else if (!redirect) begin
            state_n = S_QUERY;
          end
        end
        S_QUERY: begin
          qry = 1'b1;
          if (redirect || tlb_write) begin
            state_n = S_IDLE;
          end else if (bus.s0_found && bus.s0_v) begin
            state_n = S_IDLE;
          end else begin
            refill_n = ~bus.s0_found;
            state_n  = S_EXC;
          end
        end
        S_EXC: begin
          exc_tok  = 1'b1;
          exc_code = EXC_TLBL;
          if (redirect) begin
            state_n = S_IDLE;
          end else if (bus.fs_allowin) begin
            tok     = 1'b1;
            state_n = S_IDLE;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  assign bus.inst_cache_valid   = req;
  assign bus.inst_cache_addr    = reset ? 32'h0 : phys;
  assign bus.inst_cache_uncache = reset ? 1'b0 : uncache;
  assign bus.to_fs_valid        = (req & bus.inst_cache_addr_ok) | tok;
  assign bus.pfs_pc             = cur_pc;
  assign bus.pfs_exc            = exc_tok;
  assign bus.pfs_exc_code       = exc_code;
  assign bus.pfs_tlb_refill     = exc_tok && (state == S_EXC) && refill_r;
  assign bus.s0_vpn2            = qry ? cur_pc[31:13] : 19'h0;
  assign bus.s0_odd_page        = qry ? cur_pc[12] : 1'b0;
  assign bus.s0_asid            = qry ? cp0_asid : '0;

  // Redirects beat the sequential advance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cur_pc   <= RESET_PC;
      refill_r <= 1'b0;
    end else begin
      state    <= state_n;
      refill_r <= refill_n;
      if (pfs_reflush)
        cur_pc <= reflush_pc;
      else if (br_valid)
        cur_pc <= br_target;
      else if (bus.to_fs_valid)
        cur_pc <= cur_pc + {{(32-OFS_W){1'b0}}, inst_offset};
    end
  end

endmodule

// File: tb/tb_preif_utlb_stage.sv
// Directed self-checking bench for preif_utlb_stage with hand-computed
// expectations and a scripted main-TLB response.
module tb_preif_utlb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        br_valid;
  logic [31:0] br_target;
  logic        pfs_reflush;
  logic [31:0] reflush_pc;
  logic [5:0]  inst_offset;
  logic        tlb_write;
  logic [7:0]  cp0_asid;

  int checks   = 0;
  int failures = 0;

  preif_utlb_stage_if #(.ASID_W(8)) bus ();

  preif_utlb_stage #(
    .UTLB_ENTRIES (4),
    .RESET_PC     (32'hbfc00000),
    .ASID_W       (8),
    .OFS_W        (6)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .br_valid    (br_valid),
    .br_target   (br_target),
    .pfs_reflush (pfs_reflush),
    .reflush_pc  (reflush_pc),
    .inst_offset (inst_offset),
    .tlb_write   (tlb_write),
    .cp0_asid    (cp0_asid),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [31:0] target);
    br_valid  = 1'b1;
    br_target = target;
    @(posedge clk);
    #1;
    br_valid = 1'b0;
    #1;
  endtask

  task automatic setTlb(input logic found, input logic v, input logic [19:0] pfn,
                        input logic [2:0] c);
    bus.s0_found = found;
    bus.s0_v     = v;
    bus.s0_pfn   = pfn;
    bus.s0_c     = c;
  endtask

  task automatic fillPage(input string tag, input logic [31:0] va, input logic [19:0] pfn);
    applyStimulus(va);
    checkOutput({tag, "_miss"}, 32'(bus.inst_cache_valid), 32'd0);
    setTlb(1'b1, 1'b1, pfn, 3'd3);
    step();
    checkOutput({tag, "_vpn2"}, 32'(bus.s0_vpn2), 32'(va[31:13]));
    step();
    checkOutput({tag, "_addr"}, bus.inst_cache_addr, {pfn, va[11:0]});
    setTlb(1'b0, 1'b0, 20'h0, 3'd0);
  endtask

  initial begin
    reset       = 1'b1;
    br_valid    = 1'b0;
    br_target   = 32'h0;
    pfs_reflush = 1'b0;
    reflush_pc  = 32'h0;
    inst_offset = 6'd8;
    tlb_write   = 1'b0;
    cp0_asid    = 8'h05;
    bus.fs_allowin         = 1'b1;
    bus.inst_cache_addr_ok = 1'b1;
    setTlb(1'b0, 1'b0, 20'h0, 3'd0);

    #1;
    checkOutput("rst_valid", 32'(bus.inst_cache_valid), 32'd0);
    checkOutput("rst_pc", bus.pfs_pc, 32'hbfc00000);
    checkOutput("rst_to_fs", 32'(bus.to_fs_valid), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checkOutput("boot_valid", 32'(bus.inst_cache_valid), 32'd1);
    checkOutput("boot_addr", bus.inst_cache_addr, 32'h1fc00000);
    checkOutput("boot_uncache", 32'(bus.inst_cache_uncache), 32'd1);
    step();
    checkOutput("boot_addr2", bus.inst_cache_addr, 32'h1fc00008);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_rst_pc", bus.pfs_pc, 32'hbfc00000);
    checkOutput("async_rst_valid", 32'(bus.inst_cache_valid), 32'd0);
    #1 reset = 1'b0;
    #1;
    checkOutput("rerun_addr", bus.inst_cache_addr, 32'h1fc00000);
    inst_offset = 6'd4;

    // mapped miss, refill, then a zero-cycle hit on the next word
    applyStimulus(32'h00400000);
    checkOutput("miss_noreq", 32'(bus.inst_cache_valid), 32'd0);
    setTlb(1'b1, 1'b1, 20'h01234, 3'd3);
    step();
    checkOutput("query_vpn2", 32'(bus.s0_vpn2), 32'h00200);
    checkOutput("query_asid", 32'(bus.s0_asid), 32'h05);
    checkOutput("query_noreq", 32'(bus.inst_cache_valid), 32'd0);
    step();
    checkOutput("fill_valid", 32'(bus.inst_cache_valid), 32'd1);
    checkOutput("fill_addr", bus.inst_cache_addr, 32'h01234000);
    checkOutput("fill_cached", 32'(bus.inst_cache_uncache), 32'd0);
    setTlb(1'b0, 1'b0, 20'h0, 3'd0);
    step();
    checkOutput("hit_addr", bus.inst_cache_addr, 32'h01234004);
    checkOutput("hit_valid", 32'(bus.inst_cache_valid), 32'd1);

    // TLB refill and invalid exceptions
    applyStimulus(32'h00402000);
    step();
    step();
    checkOutput("refill_exc", 32'(bus.pfs_exc), 32'd1);
    checkOutput("refill_code", 32'(bus.pfs_exc_code), 32'd2);
    checkOutput("refill_flag", 32'(bus.pfs_tlb_refill), 32'd1);
    checkOutput("refill_noreq", 32'(bus.inst_cache_valid), 32'd0);
    checkOutput("refill_tok", 32'(bus.to_fs_valid), 32'd1);
    setTlb(1'b1, 1'b0, 20'h0, 3'd3);
    applyStimulus(32'h00404000);
    step();
    step();
    checkOutput("inv_exc", 32'(bus.pfs_exc), 32'd1);
    checkOutput("inv_code", 32'(bus.pfs_exc_code), 32'd2);
    checkOutput("inv_flag", 32'(bus.pfs_tlb_refill), 32'd0);
    setTlb(1'b0, 1'b0, 20'h0, 3'd0);

    // misaligned fetch, then reflush beating a simultaneous branch
    applyStimulus(32'h80000002);
    checkOutput("adel_exc", 32'(bus.pfs_exc), 32'd1);
    checkOutput("adel_code", 32'(bus.pfs_exc_code), 32'd4);
    checkOutput("adel_noreq", 32'(bus.inst_cache_valid), 32'd0);
    checkOutput("adel_tok", 32'(bus.to_fs_valid), 32'd1);
    step();
    checkOutput("adel_next_pc", bus.pfs_pc, 32'h80000006);
    checkOutput("adel_noquery", 32'(bus.s0_vpn2), 32'h0);
    pfs_reflush = 1'b1;
    reflush_pc  = 32'hbfc00380;
    br_valid    = 1'b1;
    br_target   = 32'h00400000;
    @(posedge clk);
    #1;
    pfs_reflush = 1'b0;
    br_valid    = 1'b0;
    #1;
    checkOutput("reflush_pc", bus.pfs_pc, 32'hbfc00380);
    checkOutput("reflush_addr", bus.inst_cache_addr, 32'h1fc00380);
    applyStimulus(32'h80001000);
    checkOutput("kseg0_addr", bus.inst_cache_addr, 32'h00001000);
    checkOutput("kseg0_cached", 32'(bus.inst_cache_uncache), 32'd0);

    // four more pages wrap the round-robin pointer onto the first entry
    fillPage("pg1", 32'h00410000, 20'h00010);
    fillPage("pg2", 32'h00420000, 20'h00020);
    fillPage("pg3", 32'h00430000, 20'h00030);
    fillPage("pg4", 32'h00440000, 20'h00040);
    applyStimulus(32'h00400000);
    checkOutput("evicted_miss", 32'(bus.inst_cache_valid), 32'd0);
    applyStimulus(32'h00430000);
    checkOutput("kept_hit", bus.inst_cache_addr, 32'h00030000);
    checkOutput("kept_valid", 32'(bus.inst_cache_valid), 32'd1);

    // flush, then a flush that lands on the QUERY cycle
    tlb_write = 1'b1;
    @(posedge clk);
    #1 tlb_write = 1'b0;
    #1;
    checkOutput("flush_miss", 32'(bus.inst_cache_valid), 32'd0);
    checkOutput("flush_pc", bus.pfs_pc, 32'h00430004);
    step();
    checkOutput("flush_query", 32'(bus.s0_vpn2), 32'h00218);
    tlb_write = 1'b1;
    setTlb(1'b1, 1'b1, 20'h05555, 3'd2);
    @(posedge clk);
    #1 tlb_write = 1'b0;
    #1;
    checkOutput("abort_nofill", 32'(bus.inst_cache_valid), 32'd0);
    checkOutput("abort_noquery", 32'(bus.s0_vpn2), 32'h0);
    step();
    checkOutput("requery_vpn2", 32'(bus.s0_vpn2), 32'h00218);
    step();
    checkOutput("requery_addr", bus.inst_cache_addr, 32'h05555004);
    checkOutput("requery_uncache", 32'(bus.inst_cache_uncache), 32'd1);
    setTlb(1'b0, 1'b0, 20'h0, 3'd0);

    // IF stall holds the PC and drops the request
    bus.fs_allowin = 1'b0;
    #1;
    checkOutput("stall_noreq", 32'(bus.inst_cache_valid), 32'd0);
    checkOutput("stall_notok", 32'(bus.to_fs_valid), 32'd0);
    step();
    checkOutput("stall_hold_pc", bus.pfs_pc, 32'h00430004);
    bus.fs_allowin = 1'b1;
    #1;
    checkOutput("resume_valid", 32'(bus.inst_cache_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
